// File: rtl/pc_stack.sv
// Program counter with relative branch, absolute jump, global stall and a
// small LIFO return-address stack for call/ret.
module pc_stack #(
  parameter int Psize  = 8,
  parameter int Osize  = 4,
  parameter int Sdepth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             PCincr,
  input  logic             branch,
  input  logic [Osize-1:0] boff,
  input  logic             jump,
  input  logic             call,
  input  logic             ret,
  input  logic [Psize-1:0] jaddr,
  output logic [Psize-1:0] PCout,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             stk_err
);
  localparam int CW = $clog2(Sdepth + 1);

  logic [CW-1:0]    cnt;
  logic [Psize-1:0] stk [Sdepth];
  logic [Psize-1:0] top, inc, opnd, seq;

  assign stk_empty = (cnt == '0);
  assign stk_full  = (cnt == CW'(Sdepth));

  // Shared adder for sequential/relative targets; separate incrementer for pushes.
  assign opnd = branch ? Psize'($signed(boff)) : Psize'(1);
  assign seq  = PCout + opnd;
  assign inc  = PCout + Psize'(1);

  always_comb begin
    top = '0;
    for (int i = 0; i < Sdepth; i++)
      if (cnt == CW'(i + 1)) top = stk[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      PCout   <= '0;
      cnt     <= '0;
      stk_err <= 1'b0;
    end else if (en) begin
      if (ret) begin
        if (!stk_empty) begin
          PCout <= top;
          cnt   <= cnt - CW'(1);
        end else begin
          PCout   <= inc;
          stk_err <= 1'b1;
        end
      end else if (call) begin
        if (!stk_full) begin
          for (int i = 0; i < Sdepth; i++)
            if (cnt == CW'(i)) stk[i] <= inc;
          cnt <= cnt + CW'(1);
        end else begin
          stk_err <= 1'b1;
        end
        PCout <= jaddr;
      end else if (jump) begin
        PCout <= jaddr;
      end else if (branch || PCincr) begin
        PCout <= seq;
      end
    end
  end
endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: a behavioural model queues expected state
// per command, compared one cycle later against the registered outputs.
module tb_pc_stack;
  logic       clk = 1'b0;
  logic       reset, en, PCincr, branch, jump, call, ret;
  logic [3:0] boff;
  logic [7:0] jaddr;
  logic [7:0] PCout;
  logic       stk_empty, stk_full, stk_err;

  typedef struct packed {
    logic [7:0] pc;
    logic       empty, full, err;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0, n_fail = 0;
  logic [7:0] mpc;
  logic [7:0] mstk[$];
  logic       merr;

  pc_stack #(.Psize(8), .Osize(4), .Sdepth(4)) dut (
    .clk(clk), .reset(reset), .en(en), .PCincr(PCincr), .branch(branch),
    .boff(boff), .jump(jump), .call(call), .ret(ret), .jaddr(jaddr),
    .PCout(PCout), .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command, update the model, then compare after the edge.
  task automatic cmd(input string tag, input logic r, input logic e, input logic inc,
                     input logic br, input logic [3:0] bo, input logic j,
                     input logic c, input logic rt, input logic [7:0] ja);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; PCincr = inc; branch = br; boff = bo;
    jump = j; call = c; ret = rt; jaddr = ja;
    if (r) begin
      mpc = 8'h00; mstk.delete(); merr = 1'b0;
    end else if (e) begin
      if (rt) begin
        if (mstk.size() > 0) mpc = mstk.pop_back();
        else begin mpc = mpc + 8'd1; merr = 1'b1; end
      end else if (c) begin
        if (mstk.size() < 4) mstk.push_back(mpc + 8'd1);
        else merr = 1'b1;
        mpc = ja;
      end else if (j)   mpc = ja;
      else if (br)      mpc = mpc + {{4{bo[3]}}, bo};
      else if (inc)     mpc = mpc + 8'd1;
    end
    x.pc = mpc; x.empty = (mstk.size() == 0); x.full = (mstk.size() == 4); x.err = merr;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".pc"},    32'(PCout),     32'(x.pc));
    chk({tag, ".empty"}, 32'(stk_empty), 32'(x.empty));
    chk({tag, ".full"},  32'(stk_full),  32'(x.full));
    chk({tag, ".err"},   32'(stk_err),   32'(x.err));
  endtask

  task automatic incr(input string t);             cmd(t, 0, 1, 1, 0, 4'd0, 0, 0, 0, 8'h00); endtask
  task automatic jmp(input string t, input logic [7:0] a); cmd(t, 0, 1, 0, 0, 4'd0, 1, 0, 0, a); endtask
  task automatic brn(input string t, input logic [3:0] o, input logic i); cmd(t, 0, 1, i, 1, o, 0, 0, 0, 8'h00); endtask
  task automatic cll(input string t, input logic [7:0] a); cmd(t, 0, 1, 0, 0, 4'd0, 0, 1, 0, a); endtask
  task automatic rtn(input string t);              cmd(t, 0, 1, 0, 0, 4'd0, 0, 0, 1, 8'h00); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; en = 1; PCincr = 0; branch = 0; boff = 0;
    jump = 0; call = 0; ret = 0; jaddr = 0;
    mpc = 0; merr = 0;

    cmd("reset", 1, 1, 0, 0, 4'd0, 0, 0, 0, 8'h00);
    chk("reset_pc", 32'(PCout), 32'h0);
    for (int i = 0; i < 3; i++) incr("incr");
    chk("incr3", 32'(PCout), 32'h3);
    jmp("jmpFF", 8'hFF);
    incr("wrapFF");
    chk("wrap_pc", 32'(PCout), 32'h0);

    jmp("j10", 8'd10);     brn("brm4", 4'b1100, 0); chk("br_neg", 32'(PCout), 32'd6);
    jmp("j250", 8'd250);   brn("br7", 4'd7, 0);     chk("br_wrap", 32'(PCout), 32'd1);
    jmp("j6", 8'd6);       brn("br2inc", 4'd2, 1);  chk("br_over_incr", 32'(PCout), 32'd8);

    jmp("j5", 8'h05); cll("call40", 8'h40);
    chk("call_pc", 32'(PCout), 32'h40);
    rtn("ret06");
    chk("ret_pc", 32'(PCout), 32'h06);
    chk("ret_err", 32'(stk_err), 32'h0);

    for (int i = 1; i <= 5; i++) begin
      jmp("jn", 8'(i));
      cll("calln", 8'(i * 16));
      if (i == 4) chk("full4", 32'(stk_full), 32'h1);
    end
    chk("call5_pc", 32'(PCout), 32'h50);
    chk("call5_err", 32'(stk_err), 32'h1);
    for (int i = 0; i < 4; i++) begin
      rtn("retn");
      chk("retn_pc", 32'(PCout), 32'(5 - i));
    end
    rtn("ret_empty");
    chk("ret_empty_pc", 32'(PCout), 32'h3);
    chk("ret_empty_err", 32'(stk_err), 32'h1);

    cll("call_pre_stall", 8'h22);
    cmd("stall_call", 0, 0, 1, 0, 4'd0, 0, 1, 0, 8'h77);
    cmd("stall_ret",  0, 0, 1, 0, 4'd0, 0, 0, 1, 8'h00);
    cmd("stall_jmp",  0, 0, 1, 1, 4'd3, 1, 0, 0, 8'h99);
    chk("stall_pc", 32'(PCout), 32'h22);
    incr("post_stall");
    chk("post_stall_pc", 32'(PCout), 32'h23);

    cmd("call_ret_same", 0, 1, 0, 0, 4'd0, 0, 1, 1, 8'h60);
    chk("call_ret_same_pc", 32'(PCout), 32'h04);

    cll("c2a", 8'h30); cll("c2b", 8'h31);
    cmd("reset_call", 1, 1, 0, 0, 4'd0, 0, 1, 0, 8'h44);
    chk("rst_pc", 32'(PCout), 32'h0);
    chk("rst_empty", 32'(stk_empty), 32'h1);
    chk("rst_err", 32'(stk_err), 32'h0);
    rtn("ret_after_rst");
    chk("rar_pc", 32'(PCout), 32'h1);
    chk("rar_err", 32'(stk_err), 32'h1);

    cmd("reset2", 1, 1, 0, 0, 4'd0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 60; i++)
      cmd("rand", 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 5) != 0),
          1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), 8'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
